// File: rtl/mem_order_queue_pkg.sv
// Shared helpers for the memory-ordering queue: store-ness decode, address
// slicing and the "no selection" index constant.
package mem_order_pkg;

    localparam int unsigned NO_IDX = 0;

    // Stations at or above n_ld are store stations.
    function automatic logic is_store(input int unsigned idx, input int unsigned n_ld);
        return idx >= n_ld;
    endfunction

    // Bit offset of station s inside the packed address bus.
    function automatic int unsigned addr_lsb(input int unsigned s, input int unsigned addr_w);
        return s * addr_w;
    endfunction

endpackage

// File: rtl/mem_order_queue_pick.sv
// Oldest-eligible selection with address-hazard check against all older entries.
// Optional MEM_ORDER_LDLD_BYPASS_EN lets loads pass older loads unconditionally.
module mem_order_pick
    import mem_order_pkg::*;
#(
    parameter int N_LD   = 3,
    parameter int N_ST   = 2,
    parameter int ADDR_W = 64,
    parameter int DEPTH  = N_LD + N_ST,
    parameter int IDX_W  = $clog2(N_LD + N_ST),
    parameter int CNT_W  = $clog2(DEPTH + 1),
    parameter int POS_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [DEPTH*IDX_W-1:0]           q_flat,
    input  logic [CNT_W-1:0]                 count,
    input  logic [N_LD+N_ST-1:0]             addr_ready,
    input  logic [(N_LD+N_ST)*ADDR_W-1:0]    addr_bus,
    output logic                             sel_valid,
    output logic [POS_W-1:0]                 sel_pos,
    output logic [IDX_W-1:0]                 sel_idx
);

    localparam int N_TOT = N_LD + N_ST;

    logic [DEPTH-1:0]  e_rdy;
    logic [DEPTH-1:0]  e_ld;
    logic [ADDR_W-1:0] e_addr [DEPTH];
    logic [IDX_W-1:0]  qk;

    // Per-entry view of the station it refers to; out-of-range indices look not-ready.
    always_comb begin
        qk = '0;
        for (int k = 0; k < DEPTH; k++) begin
            qk        = q_flat[k*IDX_W +: IDX_W];
            e_rdy[k]  = 1'b0;
            e_addr[k] = '0;
            if (32'(qk) < N_TOT) begin
                e_rdy[k]  = addr_ready[qk];
                e_addr[k] = addr_bus[addr_lsb(32'(qk), ADDR_W) +: ADDR_W];
            end
            e_ld[k] = !is_store(32'(qk), N_LD);
        end
    end

    logic ok;
    logic haz;

    always_comb begin
        sel_valid = 1'b0;
        sel_pos   = '0;
        sel_idx   = IDX_W'(NO_IDX);
        ok        = 1'b0;
        haz       = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ok = (CNT_W'(i) < count) && e_rdy[i];
            for (int j = 0; j < i; j++) begin
                haz = !e_rdy[j] || (e_addr[j] == e_addr[i]);
`ifdef MEM_ORDER_LDLD_BYPASS_EN
                if (e_ld[i] && e_ld[j])
                    haz = 1'b0;
`endif
                if (haz)
                    ok = 1'b0;
            end
            if (ok && !sel_valid) begin
                sel_valid = 1'b1;
                sel_pos   = POS_W'(i);
                sel_idx   = q_flat[i*IDX_W +: IDX_W];
            end
        end
    end

endmodule

// File: rtl/mem_order_queue.sv
// Age-ordered load/store queue: append at tail, remove the selected entry on fire.
// Build option MEM_ORDER_LDLD_BYPASS_EN is honoured inside mem_order_pick.
module mem_order_queue
    import mem_order_pkg::*;
#(
    parameter int N_LD   = 3,
    parameter int N_ST   = 2,
    parameter int ADDR_W = 64,
    parameter int DEPTH  = N_LD + N_ST,
    parameter int IDX_W  = $clog2(N_LD + N_ST)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            alloc_valid,
    input  logic [IDX_W-1:0]                alloc_idx,
    input  logic [N_LD+N_ST-1:0]            addr_ready,
    input  logic [(N_LD+N_ST)*ADDR_W-1:0]   addr_bus,
    output logic                            mem_valid,
    output logic [IDX_W-1:0]                mem_idx,
    output logic                            mem_is_store,
    input  logic                            mem_ready,
    output logic [$clog2(DEPTH+1)-1:0]      count,
    output logic                            full,
    output logic                            empty,
    output logic                            err_overflow
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int POS_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IDX_W-1:0]       q   [DEPTH];
    logic [IDX_W-1:0]       q_n [DEPTH];
    logic [DEPTH*IDX_W-1:0] q_flat;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic                   err;

    logic                   sel_valid;
    logic [POS_W-1:0]       sel_pos;
    logic [IDX_W-1:0]       sel_idx;
    logic                   fire;
    logic                   alloc_ok;
    logic [CNT_W-1:0]       wpos;

    always_comb begin
        for (int k = 0; k < DEPTH; k++)
            q_flat[k*IDX_W +: IDX_W] = q[k];
    end

    mem_order_pick #(
        .N_LD(N_LD), .N_ST(N_ST), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .IDX_W(IDX_W), .CNT_W(CNT_W), .POS_W(POS_W)
    ) u_pick (
        .q_flat(q_flat), .count(cnt), .addr_ready(addr_ready), .addr_bus(addr_bus),
        .sel_valid(sel_valid), .sel_pos(sel_pos), .sel_idx(sel_idx)
    );

    // Valid/ready: a transfer happens on any cycle with mem_valid && mem_ready;
    // mem_valid is purely combinational from queue state and address inputs.
    assign fire     = sel_valid && mem_ready;
    assign full     = (cnt == CNT_W'(DEPTH));
    assign empty    = (cnt == '0);
    assign alloc_ok = alloc_valid && (!full || fire);
    assign wpos     = fire ? cnt - CNT_W'(1) : cnt;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            q_n[k] = q[k];
            if (fire && k < DEPTH - 1 && POS_W'(k) >= sel_pos)
                q_n[k] = q[k+1];
            if (alloc_ok && wpos == CNT_W'(k))
                q_n[k] = alloc_idx;
        end
    end

    always_comb begin
        unique case ({alloc_ok, fire})
            2'b10:   cnt_n = cnt + CNT_W'(1);
            2'b01:   cnt_n = cnt - CNT_W'(1);
            default: cnt_n = cnt;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
            for (int k = 0; k < DEPTH; k++)
                q[k] <= '0;
        end else if (flush) begin
            cnt <= '0;
            for (int k = 0; k < DEPTH; k++)
                q[k] <= '0;
        end else begin
            cnt <= cnt_n;
            q   <= q_n;
            if (alloc_valid && full && !fire)
                err <= 1'b1;
        end
    end

    assign mem_valid    = sel_valid;
    assign mem_idx      = sel_idx;
    assign mem_is_store = sel_valid && is_store(32'(sel_idx), N_LD);
    assign count        = cnt;
    assign err_overflow = err;

`ifndef SYNTHESIS
    logic dup;
    always_comb begin
        dup = 1'b0;
        for (int k = 0; k < DEPTH; k++)
            if (CNT_W'(k) < cnt && q[k] == alloc_idx && !(fire && POS_W'(k) == sel_pos))
                dup = 1'b1;
    end

    a_no_dup_alloc: assert property (@(posedge clk) disable iff (rst)
        !(alloc_ok && !flush && dup));
`endif

endmodule

// File: tb/tb_mem_order_queue.sv
// Directed bench for mem_order_queue: ordering, hazards, overflow, flush, async reset.
module tb_mem_order_queue;

    localparam int N_LD = 3, N_ST = 2, ADDR_W = 64, DEPTH = 5, IDX_W = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic                  alloc_valid;
    logic [IDX_W-1:0]      alloc_idx;
    logic [4:0]            addr_ready;
    logic [5*ADDR_W-1:0]   addr_bus;
    logic                  mem_valid;
    logic [IDX_W-1:0]      mem_idx;
    logic                  mem_is_store;
    logic                  mem_ready;
    logic [2:0]            count;
    logic                  full, empty, err_overflow;

    int n_tests = 0;
    int n_fail  = 0;
    logic [IDX_W-1:0] exp_q[$];

    mem_order_queue dut (
        .clk(clk), .rst(rst), .flush(flush), .alloc_valid(alloc_valid),
        .alloc_idx(alloc_idx), .addr_ready(addr_ready), .addr_bus(addr_bus),
        .mem_valid(mem_valid), .mem_idx(mem_idx), .mem_is_store(mem_is_store),
        .mem_ready(mem_ready), .count(count), .full(full), .empty(empty),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int s, input logic [ADDR_W-1:0] a);
        addr_bus[s*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic alloc(input logic [IDX_W-1:0] idx);
        alloc_valid = 1'b1;
        alloc_idx   = idx;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic chk_sel(input string tag, input logic v, input logic [IDX_W-1:0] idx, input logic st);
        chk({tag, "_valid"}, 64'(mem_valid), 64'(v));
        chk({tag, "_idx"},   64'(mem_idx),   64'(idx));
        chk({tag, "_store"}, 64'(mem_is_store), 64'(st));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_idx = '0;
        addr_ready = '0; addr_bus = '0; mem_ready = 1'b0;
        tick();
        #1;
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full",  64'(full),  64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_err",   64'(err_overflow), 64'd0);
        chk_sel("rst_sel", 1'b0, 3'd0, 1'b0);
        rst = 1'b0;
        tick();

        // mem_ready on an empty queue does nothing
        mem_ready = 1'b1;
        tick();
        chk("empty_ready_count", 64'(count), 64'd0);
        mem_ready = 1'b0;

        // store 3 then load 0, distinct addresses
        addr_ready = 5'b01001;
        set_addr(3, 64'h100);
        set_addr(0, 64'h200);
        alloc(3'd3);
        alloc(3'd0);
        #1;
        chk_sel("st_ld", 1'b1, 3'd3, 1'b1);
        chk("st_ld_count", 64'(count), 64'd2);

        // same address: load waits behind store; drain in age order
        set_addr(0, 64'h100);
        mem_ready = 1'b1;
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd0);
        #1;
        chk("drain0_idx", 64'(mem_idx), 64'(exp_q.pop_front()));
        tick();
        chk("drain1_count", 64'(count), 64'd1);
        chk_sel("drain1", 1'b1, exp_q.pop_front(), 1'b0);
        tick();
        chk("drain2_count", 64'(count), 64'd0);
        chk("drain2_valid", 64'(mem_valid), 64'd0);
        mem_ready = 1'b0;

        // unknown older store address blocks the younger load
        addr_ready = 5'b00010;
        set_addr(1, 64'h40);
        alloc(3'd4);
        alloc(3'd1);
        #1;
        chk("blocked_valid", 64'(mem_valid), 64'd0);
        addr_ready = 5'b10010;
        set_addr(4, 64'h80);
        #1;
        chk_sel("unblk", 1'b1, 3'd4, 1'b1);
        mem_ready = 1'b1;
        tick();
        chk_sel("unblk_next", 1'b1, 3'd1, 1'b0);
        tick();
        mem_ready = 1'b0;
        chk("unblk_count", 64'(count), 64'd0);

        // fill, overflow without fire, then accepted alloc with fire
        addr_ready = '0;
        for (int s = 0; s < 5; s++) begin
            set_addr(s, 64'h1000 + 64'(s) * 8);
            alloc(3'(s));
        end
        chk("fill_full",  64'(full),  64'd1);
        chk("fill_count", 64'(count), 64'd5);
        alloc(3'd2);
        chk("ovf_err",   64'(err_overflow), 64'd1);
        chk("ovf_count", 64'(count), 64'd5);
        addr_ready = 5'b00001;
        mem_ready  = 1'b1;
        alloc(3'd0);
        mem_ready  = 1'b0;
        chk("ovf_fire_count", 64'(count), 64'd5);
        chk("ovf_fire_full",  64'(full),  64'd1);
        addr_ready = 5'b11111;
        exp_q = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        mem_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("order_valid", 64'(mem_valid), 64'd1);
            chk("order_idx",   64'(mem_idx),   64'(exp_q.pop_front()));
            tick();
        end
        mem_ready = 1'b0;
        chk("order_count", 64'(count), 64'd0);
        chk("err_sticky",  64'(err_overflow), 64'd1);

        // load/load pair with equal address, older address unknown
        addr_ready = '0;
        set_addr(0, 64'h10);
        set_addr(1, 64'h10);
        alloc(3'd0);
        alloc(3'd1);
        addr_ready = 5'b00010;
        #1;
`ifdef MEM_ORDER_LDLD_BYPASS_EN
        chk_sel("ldld", 1'b1, 3'd1, 1'b0);
`else
        chk_sel("ldld", 1'b0, 3'd0, 1'b0);
`endif

        // flush beats alloc and fire
        flush = 1'b1; alloc_valid = 1'b1; alloc_idx = 3'd2; mem_ready = 1'b1;
        tick();
        flush = 1'b0; alloc_valid = 1'b0; mem_ready = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        chk("flush_valid", 64'(mem_valid), 64'd0);
        chk("flush_err",   64'(err_overflow), 64'd1);

        // asynchronous reset mid-cycle
        addr_ready = 5'b01000;
        alloc(3'd3);
        chk("pre_rst_count", 64'(count), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_empty", 64'(empty), 64'd1);
        chk("arst_valid", 64'(mem_valid), 64'd0);
        chk("arst_err",   64'(err_overflow), 64'd0);
        #3;
        rst = 1'b0;
        tick();
        chk("post_rst_count", 64'(count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
